// File: rtl/fifo_array_skew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_array_skew_ctrl
// Purpose  : Read scheduler for the per-lane FIFO array feeding the systolic
//            PE grid. After start, each lane is drained of len words, and
//            lane i starts i cycles after lane 0 (diagonal skew). All lanes
//            stall together whenever any active lane is empty, so the
//            wavefront stays aligned.
// Ports    : clk          - single clock shared with the FIFO array
//            rst_n        - asynchronous active-low reset
//            start        - one-cycle drain request (ignored unless idle)
//            len          - words per lane, latched when start is accepted
//            abort        - stop the drain and clear the FIFO array
//            empty        - per-lane empty flags from the FIFO array
//            r_en         - per-lane read enables (combinational)
//            lane_valid   - FIFO dataOut of lane i is valid this cycle
//            clear        - one-cycle clear pulse to the FIFO array
//            busy         - high while draining or flushing
//            done         - one-cycle pulse when a drain completes
//            stall_cycles - (SKEW_STALL_COUNT_EN only) saturating count of
//                           stalled RUN cycles in the current/last drain
// Config   : define SKEW_STALL_COUNT_EN to add the stall_cycles counter.
// Revision : 1.0  initial release
// ============================================================================
module fifo_array_skew_ctrl #(
    parameter int ARRAY_SIZE = 9,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic                  abort,
    input  logic [ARRAY_SIZE-1:0] empty,
    output logic [ARRAY_SIZE-1:0] r_en,
    output logic [ARRAY_SIZE-1:0] lane_valid,
    output logic                  clear,
    output logic                  busy,
    output logic                  done
`ifdef SKEW_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    // Time index must hold len_q + ARRAY_SIZE - 1 without wrapping.
    localparam int c_T_W = LEN_W + $clog2(ARRAY_SIZE) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [c_T_W-1:0]      r_t;
    logic [LEN_W-1:0]      r_len_q;
    logic [ARRAY_SIZE-1:0] r_lane_valid;
    logic                  r_clear;

    logic [c_T_W-1:0]      w_len_ext;
    logic [c_T_W-1:0]      w_last_t;
    logic [ARRAY_SIZE-1:0] w_active;
    logic                  w_in_run;
    logic                  w_stall;
    logic                  w_go;
    logic                  w_accept;

    assign w_len_ext = {{(c_T_W-LEN_W){1'b0}}, r_len_q};
    assign w_last_t  = w_len_ext + c_T_W'(ARRAY_SIZE) - c_T_W'(2);

    // Lane i is active on time steps [i, i+len_q).
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        localparam logic [c_T_W-1:0] c_IDX = c_T_W'(i);
        assign w_active[i] = (r_t >= c_IDX) && (r_t < (c_IDX + w_len_ext));
    end

    assign w_in_run = (r_state == c_RUN);
    assign w_stall  = w_in_run && |(w_active & empty);
    assign w_go     = w_in_run && !w_stall && !abort;
    assign w_accept = (r_state == c_IDLE) && start && (len != '0) && !abort;

    assign r_en       = {ARRAY_SIZE{w_go}} & w_active;
    // Gated so the data is marked invalid in the very cycle abort lands.
    assign lane_valid = abort ? '0 : r_lane_valid;
    assign clear      = r_clear;
    assign busy       = (r_state == c_RUN) || (r_state == c_FLUSH);
    assign done       = (r_state == c_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_t          <= '0;
            r_len_q      <= '0;
            r_lane_valid <= '0;
            r_clear      <= 1'b0;
        end else begin
            r_clear      <= abort;
            r_lane_valid <= abort ? '0 : r_en;
            if (abort) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_accept) begin
                            r_len_q <= len;
                            r_t     <= '0;
                            r_state <= c_RUN;
                        end
                    end
                    c_RUN: begin
                        if (!w_stall) begin
                            r_t <= r_t + c_T_W'(1);
                            if (r_t == w_last_t) begin
                                r_state <= c_FLUSH;
                            end
                        end
                    end
                    c_FLUSH: r_state <= c_DONE;
                    c_DONE:  r_state <= c_IDLE;
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

`ifdef SKEW_STALL_COUNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !abort && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire
